// File: rtl/fp_multiply_pipe.sv
// fp_multiply_pipe: three-stage floating-point multiplier with valid/ready
// backpressure, round-to-nearest-even, inf/NaN handling and exception flags.
// Subnormal operands and results are flushed to signed zero.
// flags = {invalid, overflow, underflow, inexact}, aligned with c.
module fp_multiply_pipe #(
  parameter int EXP_W    = 5,
  parameter int MAN_W    = 10,
  parameter int SAT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] c,
  output logic [3:0]           flags
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int EW2    = EXP_W + 2;
  localparam int PW     = 2 * MAN_W + 2;
  localparam int BIAS_I = (2 ** (EXP_W - 1)) - 1;
  localparam int EMAX_I = (2 ** EXP_W) - 1;

  localparam logic signed [EW2-1:0] BIAS_S   = EW2'(BIAS_I);
  localparam logic signed [EW2-1:0] EMAX_S   = EW2'(EMAX_I);
  localparam logic signed [EW2-1:0] ZERO_S   = {EW2{1'b0}};
  localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]      EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0]      EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
  localparam logic [MAN_W-1:0]      MAN_ZERO = {MAN_W{1'b0}};
  localparam logic [MAN_W-1:0]      MAN_ONES = {MAN_W{1'b1}};
  localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // Operand class carried down the pipe; the special classes bypass the
  // arithmetic and only select a fixed result pattern in the last stage.
  typedef enum logic [1:0] {
    K_NORM = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_t;

  logic en_s;

  // Stage 1 combinational signals
  logic                  sa_s, sb_s;
  logic [EXP_W-1:0]      ea_s, eb_s;
  logic [MAN_W-1:0]      fa_s, fb_s;
  logic                  za_s, zb_s, ia_s, ib_s, na_s, nb_s;
  kind_t                 kind1_s;
  logic [PW-1:0]         mant_a_s, mant_b_s, prod_s;
  logic signed [EW2-1:0] exp_sum_s;

  // Stage 1 registers
  logic                  v1_r;
  kind_t                 kind1_r;
  logic                  sign1_r;
  logic signed [EW2-1:0] exp1_r;
  logic [PW-1:0]         prod1_r;

  // Stage 2 combinational signals
  logic [PW-2:0]         norm_s;
  logic [MAN_W-1:0]      frac_raw_s;
  logic                  guard_s, sticky_s, round_up_s;
  logic [MAN_W:0]        frac_sum_s;
  logic signed [EW2-1:0] exp_rnd_s;

  // Stage 2 registers
  logic                  v2_r;
  kind_t                 kind2_r;
  logic                  sign2_r;
  logic signed [EW2-1:0] exp2_r;
  logic [MAN_W-1:0]      frac2_r;
  logic                  inexact2_r;

  // Stage 3 combinational signals
  logic [W-1:0]          c_s;
  logic [3:0]            flags_s;

  // Global stall: the whole pipe moves only when the output slot can drain.
  assign en_s     = !out_valid | out_ready;
  assign in_ready = en_s;

  assign sa_s = a[W-1];
  assign sb_s = b[W-1];
  assign ea_s = a[MAN_W +: EXP_W];
  assign eb_s = b[MAN_W +: EXP_W];
  assign fa_s = a[MAN_W-1:0];
  assign fb_s = b[MAN_W-1:0];

  assign za_s = (ea_s == EXP_ZERO);
  assign zb_s = (eb_s == EXP_ZERO);
  assign ia_s = (ea_s == EXP_ONES) && (fa_s == MAN_ZERO);
  assign ib_s = (eb_s == EXP_ONES) && (fb_s == MAN_ZERO);
  assign na_s = (ea_s == EXP_ONES) && (fa_s != MAN_ZERO);
  assign nb_s = (eb_s == EXP_ONES) && (fb_s != MAN_ZERO);

  assign mant_a_s  = {{(MAN_W+1){1'b0}}, 1'b1, fa_s};
  assign mant_b_s  = {{(MAN_W+1){1'b0}}, 1'b1, fb_s};
  assign prod_s    = mant_a_s * mant_b_s;
  assign exp_sum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;

  // Classify the operand pair; NaN and inf*zero outrank inf, inf outranks zero.
  always_comb begin
    kind1_s = K_NORM;
    if (na_s | nb_s | (ia_s & zb_s) | (za_s & ib_s)) begin
      kind1_s = K_NAN;
    end else if (ia_s | ib_s) begin
      kind1_s = K_INF;
    end else if (za_s | zb_s) begin
      kind1_s = K_ZERO;
    end else begin
      kind1_s = K_NORM;
    end
  end

  // Stage 1 register: class, sign, biased exponent sum and full significand product.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v1_r    <= 1'b0;
      kind1_r <= K_NORM;
      sign1_r <= 1'b0;
      exp1_r  <= ZERO_S;
      prod1_r <= {PW{1'b0}};
    end else if (en_s) begin
      v1_r    <= in_valid;
      kind1_r <= kind1_s;
      sign1_r <= sa_s ^ sb_s;
      exp1_r  <= exp_sum_s;
      prod1_r <= prod_s;
    end
  end

  // Normalise so the leading one sits just above the kept fraction bits.
  always_comb begin
    norm_s = prod1_r[PW-2:0];
    if (prod1_r[PW-1]) begin
      norm_s = prod1_r[PW-2:0];
    end else begin
      norm_s = {prod1_r[PW-3:0], 1'b0};
    end
  end

  assign frac_raw_s = norm_s[PW-2 -: MAN_W];
  assign guard_s    = norm_s[MAN_W];
  assign sticky_s   = |norm_s[MAN_W-1:0];
  assign round_up_s = guard_s & (sticky_s | frac_raw_s[0]);
  assign frac_sum_s = {1'b0, frac_raw_s} + {{MAN_W{1'b0}}, round_up_s};
  // A carry out of the fraction leaves it all-zero, so only the exponent bumps.
  assign exp_rnd_s  = exp1_r
                    + $signed({{(EW2-1){1'b0}}, prod1_r[PW-1]})
                    + $signed({{(EW2-1){1'b0}}, frac_sum_s[MAN_W]});

  // Stage 2 register: rounded fraction, adjusted exponent and inexact bit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      v2_r       <= 1'b0;
      kind2_r    <= K_NORM;
      sign2_r    <= 1'b0;
      exp2_r     <= ZERO_S;
      frac2_r    <= MAN_ZERO;
      inexact2_r <= 1'b0;
    end else if (en_s) begin
      v2_r       <= v1_r;
      kind2_r    <= kind1_r;
      sign2_r    <= sign1_r;
      exp2_r     <= exp_rnd_s;
      frac2_r    <= frac_sum_s[MAN_W-1:0];
      inexact2_r <= guard_s | sticky_s;
    end
  end

  // Range check and pack; bubbles produce an all-zero result and flags.
  always_comb begin
    c_s     = {W{1'b0}};
    flags_s = 4'b0000;
    if (!v2_r) begin
      c_s     = {W{1'b0}};
      flags_s = 4'b0000;
    end else begin
      case (kind2_r)
        K_NAN: begin
          c_s     = QNAN;
          flags_s = 4'b1000;
        end
        K_INF: begin
          c_s     = {sign2_r, EXP_ONES, MAN_ZERO};
          flags_s = 4'b0000;
        end
        K_ZERO: begin
          c_s     = {sign2_r, EXP_ZERO, MAN_ZERO};
          flags_s = 4'b0000;
        end
        K_NORM: begin
          if (exp2_r >= EMAX_S) begin
            flags_s = 4'b0101;
            if (SAT_MODE != 32'sd0) begin
              c_s = {sign2_r, EXP_MAXF, MAN_ONES};
            end else begin
              c_s = {sign2_r, EXP_ONES, MAN_ZERO};
            end
          end else if (exp2_r <= ZERO_S) begin
            c_s     = {sign2_r, EXP_ZERO, MAN_ZERO};
            flags_s = 4'b0011;
          end else begin
            c_s     = {sign2_r, exp2_r[EXP_W-1:0], frac2_r};
            flags_s = {3'b000, inexact2_r};
          end
        end
        default: begin
          c_s     = {W{1'b0}};
          flags_s = 4'b0000;
        end
      endcase
    end
  end

  // Output register: holds c/flags steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      c         <= {W{1'b0}};
      flags     <= 4'b0000;
    end else if (en_s) begin
      out_valid <= v2_r;
      c         <= c_s;
      flags     <= flags_s;
    end
  end

endmodule
